vc_fifo_arbiter: RTL and testbench

- Schedules traffic from four input virtual-channel FIFOs (8-bit data, synchronous active-low reset) into four egress FIFOs of the same type.
- Pops one word at a time from a granted input FIFO, decodes the destination field and pushes the word into the selected egress FIFO.
- Honours egress back-pressure (pause) and input emptiness.
- Sits between the ingress VC FIFO bank and the egress FIFO bank of the switch.

---
 rtl/vc_fifo_arbiter.sv | 166 ++++++++++++++++
 tb/tb_vc_fifo_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_fifo_arbiter.sv
// rtl/vc_fifo_arbiter.sv - moves words from four ingress VC FIFOs to four egress FIFOs by destination field
module vc_fifo_arbiter #(
    parameter int DATA_SIZE = 8,
    parameter int N_VC      = 4,
    parameter int DEST_MSB  = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      arb_mode,
    input  logic [N_VC-1:0]           in_empty,
    input  logic [N_VC*DATA_SIZE-1:0] in_data,
    input  logic [N_VC-1:0]           in_error,
    input  logic [N_VC-1:0]           out_pause,
    input  logic [N_VC-1:0]           out_error,
    output logic [N_VC-1:0]           pop,
    output logic [N_VC-1:0]           push,
    output logic [DATA_SIZE-1:0]      data_o,
    output logic [1:0]                grant_id,
    output logic                      busy,
    output logic [7:0]                word_count,
    output logic                      err_sticky
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_WAIT,
        S_PUSH
    } state_t;

    state_t state;
    state_t state_nxt;

    // Round-robin pointer: the input served last; the scan starts one past it.
    logic [1:0] last;
    logic [1:0] last_nxt;
    // Arbitration mode captured at grant time so a mid-transfer change only affects the next grant.
    logic       mode_q;
    logic       mode_nxt;

    logic [N_VC-1:0]      pop_nxt;
    logic [N_VC-1:0]      push_nxt;
    logic [DATA_SIZE-1:0] data_nxt;
    logic [1:0]           grant_nxt;
    logic                 busy_nxt;
    logic [7:0]           count_nxt;

    logic [DATA_SIZE-1:0] in_word [N_VC];
    logic [DATA_SIZE-1:0] sel_word;
    logic [1:0]           dest;
    logic                 eligible;
    logic [1:0]           win_fix;
    logic [1:0]           win_rr;
    logic [1:0]           rr_idx;
    logic [1:0]           win;

    // Split the flat input bus into one word per VC.
    always_comb begin
        for (int i = 0; i < N_VC; i++) begin
            in_word[i] = in_data[i*DATA_SIZE +: DATA_SIZE];
        end
    end

    assign sel_word = in_word[grant_id];
    assign dest     = sel_word[DEST_MSB -: 2];

    // The destination is unknown before the pop, so any paused egress blocks a new grant.
    assign eligible = (out_pause == '0) && (in_empty != '1);

    // Winner selection: lowest non-empty index, or first non-empty index after the last served one.
    always_comb begin
        win_fix = '0;
        win_rr  = '0;
        rr_idx  = '0;
        for (int i = N_VC - 1; i >= 0; i--) begin
            if (!in_empty[i]) begin
                win_fix = 2'(i);
            end
        end
        for (int k = N_VC; k >= 1; k--) begin
            rr_idx = last + 2'(k);
            if (!in_empty[rr_idx]) begin
                win_rr = rr_idx;
            end
        end
        win = arb_mode ? win_fix : win_rr;
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            pop        <= '0;
            push       <= '0;
            data_o     <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            word_count <= '0;
            last       <= 2'd3;
            mode_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            pop        <= pop_nxt;
            push       <= push_nxt;
            data_o     <= data_nxt;
            grant_id   <= grant_nxt;
            busy       <= busy_nxt;
            word_count <= count_nxt;
            last       <= last_nxt;
            mode_q     <= mode_nxt;
        end
    end

    // Next-state and next-output decode; strobes default low so each lasts one cycle.
    always_comb begin
        state_nxt = state;
        pop_nxt   = '0;
        push_nxt  = '0;
        data_nxt  = data_o;
        grant_nxt = grant_id;
        busy_nxt  = busy;
        count_nxt = word_count;
        last_nxt  = last;
        mode_nxt  = mode_q;
        case (state)
            S_IDLE: begin
                if (eligible) begin
                    pop_nxt[win] = 1'b1;
                    grant_nxt    = win;
                    busy_nxt     = 1'b1;
                    mode_nxt     = arb_mode;
                    state_nxt    = S_POP;
                end
            end
            S_POP: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                data_nxt       = sel_word;
                push_nxt[dest] = 1'b1;
                state_nxt      = S_PUSH;
            end
            S_PUSH: begin
                count_nxt = word_count + 8'd1;
                if (!mode_q) begin
                    last_nxt = grant_id;
                end
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Any FIFO error latches until reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_sticky <= 1'b0;
        end else if ((|in_error) || (|out_error)) begin
            err_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vc_fifo_arbiter.sv
// tb/tb_vc_fifo_arbiter.sv - self-checking bench for vc_fifo_arbiter with FIFO and scheduling models
module tb_vc_fifo_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        arb_mode;
    logic [3:0]  in_empty;
    logic [31:0] in_data;
    logic [3:0]  in_error;
    logic [3:0]  out_pause;
    logic [3:0]  out_error;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [7:0]  data_o;
    logic [1:0]  grant_id;
    logic        busy;
    logic [7:0]  word_count;
    logic        err_sticky;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] fq [4][$];
    logic [7:0] mq [4][$];
    int         glog [$];

    logic       s_reset;
    logic       s_mode;
    logic [3:0] s_empty;
    logic [3:0] s_pause;
    logic       s_err;
    bit         started = 1'b0;

    always #5 clk = ~clk;

    vc_fifo_arbiter #(.DATA_SIZE(8), .N_VC(4), .DEST_MSB(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .arb_mode   (arb_mode),
        .in_empty   (in_empty),
        .in_data    (in_data),
        .in_error   (in_error),
        .out_pause  (out_pause),
        .out_error  (out_error),
        .pop        (pop),
        .push       (push),
        .data_o     (data_o),
        .grant_id   (grant_id),
        .busy       (busy),
        .word_count (word_count),
        .err_sticky (err_sticky)
    );

    always @(posedge clk) begin
        s_reset = reset;
        s_mode  = arb_mode;
        s_empty = in_empty;
        s_pause = out_pause;
        s_err   = (|in_error) || (|out_error);
        started = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] emp, input bit fixed, input logic [1:0] lst);
        if (fixed) begin
            for (int k = 0; k < 4; k++) if (!emp[k]) return k;
        end else begin
            for (int k = 1; k <= 4; k++) if (!emp[(lst + k) % 4]) return (lst + k) % 4;
        end
        return 0;
    endfunction

    task automatic refresh_empty();
        for (int i = 0; i < 4; i++) in_empty[i] = (fq[i].size() == 0);
    endtask

    task automatic load(input int vc, input logic [7:0] w);
        fq[vc].push_back(w);
        mq[vc].push_back(w);
        refresh_empty();
    endtask

    // Ingress FIFOs: a pop strobe seen in one cycle presents the word on in_data the next.
    task automatic fifo_loop();
        logic [3:0] prev = 4'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (prev[i] && fq[i].size() > 0) in_data[i*8 +: 8] = fq[i].pop_front();
            end
            refresh_empty();
            prev = pop;
        end
    endtask

    // Transaction model: a grant is followed two cycles later by the push of that VC's head word,
    // and the count moves one cycle after the push.
    task automatic monitor_loop();
        int         ph    = 0;
        int         mw    = 0;
        bit         ml    = 1'b0;
        logic [7:0] mword = 8'h00;
        logic [1:0] mlast = 2'd3;
        logic [3:0] e_pop = 4'b0;
        logic [3:0] e_push = 4'b0;
        logic [7:0] e_data = 8'h00;
        logic [1:0] e_gid = 2'd0;
        logic [7:0] e_cnt = 8'h00;
        logic       e_err = 1'b0;
        forever begin
            @(negedge clk);
            if (started) begin
                for (int i = 0; i < 4; i++) if (pop[i]) glog.push_back(i);
                if (!s_reset) begin
                    ph = 0; mlast = 2'd3; e_pop = 4'b0; e_push = 4'b0;
                    e_data = 8'h00; e_gid = 2'd0; e_cnt = 8'h00; e_err = 1'b0;
                end else begin
                    e_err = e_err | s_err;
                    e_pop = 4'b0;
                    e_push = 4'b0;
                    if (ph == 0) begin
                        if (s_pause == 4'b0 && s_empty != 4'hF) begin
                            mw = pick(s_empty, s_mode, mlast);
                            ml = s_mode;
                            e_pop = 4'(1 << mw);
                            e_gid = 2'(mw);
                            mword = (mq[mw].size() > 0) ? mq[mw].pop_front() : 8'hxx;
                            ph = 1;
                        end
                    end else if (ph == 1) begin
                        ph = 2;
                    end else if (ph == 2) begin
                        e_data = mword;
                        e_push = 4'(1 << mword[7:6]);
                        ph = 3;
                    end else begin
                        e_cnt = e_cnt + 8'd1;
                        if (!ml) mlast = 2'(mw);
                        ph = 0;
                    end
                end
                chk("m_pop", pop, e_pop);
                chk("m_push", push, e_push);
                chk("m_data_o", data_o, e_data);
                chk("m_grant_id", grant_id, e_gid);
                chk("m_busy", busy, (ph != 0));
                chk("m_word_count", word_count, e_cnt);
                chk("m_err_sticky", err_sticky, e_err);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_pop(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < 20) begin
            tick();
            n++;
            if (pop != 4'b0) ok = 1'b1;
        end
        chk("wait_pop_timeout", ok, 1);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((in_empty != 4'hF || busy) && n < budget);
        chk(name, (n < budget), 1);
    endtask

    task automatic chk_log(input string name, input int exp[$]);
        chk(name, glog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < glog.size(); i++) chk(name, glog[i], exp[i]);
    endtask

    initial begin
        bit ok;
        int exp_q [$];
        reset = 1'b0;
        arb_mode = 1'b0;
        in_error = 4'b0;
        out_pause = 4'b0;
        out_error = 4'b0;
        in_data = 32'h0;
        in_empty = 4'hF;
        fork
            fifo_loop();
            monitor_loop();
        join_none

        // Reset held with a word pending, then a single transfer VC2 -> egress 3.
        load(2, 8'hC5);
        tick();
        tick();
        chk("rst_pop", pop, 4'b0);
        chk("rst_push", push, 4'b0);
        chk("rst_word_count", word_count, 8'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_id", grant_id, 2'd0);
        reset = 1'b1;
        wait_pop(ok);
        if (ok) begin
            chk("single_pop", pop, 4'b0100);
            chk("single_grant", grant_id, 2'd2);
            tick();
            chk("single_wait_push", push, 4'b0);
            tick();
            chk("single_push", push, 4'b1000);
            chk("single_data", data_o, 8'hC5);
            tick();
            chk("single_count", word_count, 8'd1);
            chk("single_idle", busy, 1'b0);
        end

        // Round-robin over three words per VC.
        do_reset();
        arb_mode = 1'b0;
        glog.delete();
        for (int k = 0; k < 3; k++)
            for (int v = 0; v < 4; v++) load(v, {2'(k + v), 3'(v), 3'(k)});
        wait_drain(200, "rr_drain_timeout");
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
        chk_log("rr_order", exp_q);
        chk("rr_count", word_count, 8'd12);

        // Fixed priority drains VC0 before VC1.
        do_reset();
        arb_mode = 1'b1;
        glog.delete();
        for (int k = 0; k < 3; k++) load(0, {2'(k), 6'(k)});
        for (int v = 1; v < 4; v++)
            for (int k = 0; k < 2; k++) load(v, {2'(v), 3'(v), 3'(k)});
        wait_drain(200, "fix_drain_timeout");
        exp_q = '{0, 0, 0, 1, 1, 2, 2, 3, 3};
        chk_log("fix_order", exp_q);
        chk("fix_count", word_count, 8'd9);

        // Back-pressure: no pop while paused; pause rising in WAIT does not stop the push.
        do_reset();
        arb_mode = 1'b0;
        out_pause = 4'b0010;
        load(3, 8'h47);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_no_pop", pop, 4'b0);
        end
        out_pause = 4'b0000;
        tick();
        chk("bp_pop_after_release", pop, 4'b1000);
        tick();
        out_pause = 4'hF;
        tick();
        chk("bp_push_under_pause", push, 4'b0010);
        chk("bp_push_data", data_o, 8'h47);
        load(0, 8'h01);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_stall_pop", pop, 4'b0);
            chk("bp_data_hold", data_o, 8'h47);
        end
        out_pause = 4'b0;
        wait_drain(40, "bp_drain_timeout");
        chk("bp_count", word_count, 8'd2);

        // Sticky errors from either side, cleared only by reset.
        chk("err_initial", err_sticky, 1'b0);
        in_error = 4'b0010;
        tick();
        chk("err_set_in", err_sticky, 1'b1);
        in_error = 4'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("err_hold", err_sticky, 1'b1);
        do_reset();
        chk("err_cleared", err_sticky, 1'b0);
        out_error = 4'b1000;
        tick();
        out_error = 4'b0;
        chk("err_set_out", err_sticky, 1'b1);

        // Counter wrap: 255 words then one more.
        do_reset();
        arb_mode = 1'b0;
        for (int k = 0; k < 255; k++) load(k % 4, 8'(k));
        wait_drain(1300, "wrap_drain_timeout");
        chk("wrap_255", word_count, 8'd255);
        load(1, 8'hFF);
        wait_drain(20, "wrap_last_timeout");
        chk("wrap_zero", word_count, 8'd0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
